// File: rtl/ats21_pkg.sv
// ATS21 shared types: opcode and client encodings, capture states,
// decoded command record and the command-id decode helper.
package ats21_pkg;

   typedef enum logic [2:0] {
      NOP       = 3'b000,
      SET_CLK   = 3'b001,
      EN_CLK    = 3'b010,
      MODE      = 3'b011,
      RSVD      = 3'b100,
      SET_ALARM = 3'b101,
      SET_CD    = 3'b110,
      EN_AT     = 3'b111
   } opcode_e;

   typedef enum logic {
      CLIENT_A = 1'b0,
      CLIENT_B = 1'b1
   } client_e;

   typedef enum logic {
      IDLE = 1'b0,
      LOW  = 1'b1
   } cap_state_e;

   typedef struct packed {
      client_e     client;
      opcode_e     opcode;
      logic [4:0]  id;
      logic [31:0] word;
   } cmd_t;

   // Clock/alarm/timer number carried in the instruction, by opcode class
   function automatic logic [4:0] decode_id(input logic [31:0] word);
      case (opcode_e'(word[31:29]))
         SET_CLK, EN_CLK:          decode_id = {1'b0, word[28:25]};
         SET_ALARM, SET_CD, EN_AT: decode_id = word[28:24];
         default:                  decode_id = '0;
      endcase
   endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// Per-client show-ahead instruction FIFO with occupancy count.
// A push while full is only taken if the same cycle also pops.
module ats21_cmd_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap modulo DEPTH
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array write
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ats21_cmd_ingress.sv
// ATS21 command ingress: reassembles two-cycle half-word transfers from
// clients A and B, filters/queues them per client and serves one decoded
// command at a time to the scheduler core with round-robin arbitration.
module ats21_cmd_ingress
   import ats21_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [15:0] ctrlA,
   input  logic [15:0] ctrlB,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        cmd_client,
   output logic [2:0]  cmd_opcode,
   output logic [4:0]  cmd_id,
   output logic [31:0] cmd_word,
   output logic        drop_a,
   output logic        drop_b,
   output logic        proto_err
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   cap_state_e     state, state_nx;
   logic [15:0]    upper_a, upper_b;
   logic           load_upper, complete, abort;
   logic [31:0]    word_a, word_b;
   opcode_e        op_a, op_b;
   logic           want_a, want_b, rsvd_a, rsvd_b;
   logic           accept_a, accept_b, push_a, push_b, pop_a, pop_b;
   logic [31:0]    head_a, head_b;
   logic           empty_a, empty_b;
   logic [CW-1:0]  count_a, count_b;
   client_e        last, gnt, gnt_q;
   logic           stall_q;
   cmd_t           cmd;

   // Capture state register and upper-half latches
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         upper_a <= '0;
         upper_b <= '0;
      end else begin
         state <= state_nx;
         if (load_upper) begin
            upper_a <= ctrlA;
            upper_b <= ctrlB;
         end
      end
   end

   // Capture next-state: req always restarts a pair, even mid-transfer
   always_comb begin
      state_nx   = state;
      load_upper = 1'b0;
      complete   = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               load_upper = 1'b1;
               state_nx   = LOW;
            end
         end
         LOW: begin
            if (req) begin
               load_upper = 1'b1;
               abort      = 1'b1;
            end else begin
               complete = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign word_a   = {upper_a, ctrlA};
   assign word_b   = {upper_b, ctrlB};
   assign op_a     = opcode_e'(word_a[31:29]);
   assign op_b     = opcode_e'(word_b[31:29]);
   assign want_a   = complete && (op_a != NOP) && (op_a != RSVD);
   assign want_b   = complete && (op_b != NOP) && (op_b != RSVD);
   assign rsvd_a   = complete && (op_a == RSVD);
   assign rsvd_b   = complete && (op_b == RSVD);
   assign accept_a = (count_a < CW'(DEPTH)) || pop_a;
   assign accept_b = (count_b < CW'(DEPTH)) || pop_b;
   assign push_a   = want_a && accept_a;
   assign push_b   = want_b && accept_b;

   // Discard and abort indications, one cycle after the deciding capture
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_a    <= 1'b0;
         drop_b    <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         drop_a    <= rsvd_a || (want_a && !accept_a);
         drop_b    <= rsvd_b || (want_b && !accept_b);
         proto_err <= abort;
      end
   end

   ats21_cmd_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo_a (
      .clk       (clk),
      .reset     (reset),
      .push      (push_a),
      .push_data (word_a),
      .pop       (pop_a),
      .head      (head_a),
      .empty     (empty_a),
      .count     (count_a)
   );

   ats21_cmd_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo_b (
      .clk       (clk),
      .reset     (reset),
      .push      (push_b),
      .push_data (word_b),
      .pop       (pop_b),
      .head      (head_b),
      .empty     (empty_b),
      .count     (count_b)
   );

   assign cmd_valid = !empty_a || !empty_b;
   assign pop_a     = cmd_valid && cmd_ready && (gnt == CLIENT_A);
   assign pop_b     = cmd_valid && cmd_ready && (gnt == CLIENT_B);

   // Grant: held while stalled, otherwise round-robin against last served
   always_comb begin
      if (stall_q)
         gnt = gnt_q;
      else if (!empty_a && !empty_b)
         gnt = (last == CLIENT_B) ? CLIENT_A : CLIENT_B;
      else
         gnt = empty_a ? CLIENT_B : CLIENT_A;
   end

   // Arbiter state: last served client and stall lock
   always_ff @(posedge clk) begin
      if (reset) begin
         last    <= CLIENT_B;
         gnt_q   <= CLIENT_A;
         stall_q <= 1'b0;
      end else begin
         stall_q <= cmd_valid && !cmd_ready;
         gnt_q   <= gnt;
         if (cmd_valid && cmd_ready) last <= gnt;
      end
   end

   // Command mux from the granted FIFO head; all zeros when nothing is valid
   always_comb begin
      cmd = '0;
      if (cmd_valid) begin
         cmd.client = gnt;
         cmd.word   = (gnt == CLIENT_B) ? head_b : head_a;
         cmd.opcode = opcode_e'(cmd.word[31:29]);
         cmd.id     = decode_id(cmd.word);
      end
   end

   assign cmd_client = cmd.client;
   assign cmd_opcode = cmd.opcode;
   assign cmd_id     = cmd.id;
   assign cmd_word   = cmd.word;

endmodule

// File: tb/tb_ats21_cmd_ingress.sv
// Self-checking bench for ats21_cmd_ingress: directed scenarios followed by
// randomized traffic, checked every cycle against a queue-based model.
module tb_ats21_cmd_ingress;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic [15:0] ctrlA = '0;
   logic [15:0] ctrlB = '0;
   logic        cmd_ready = 1'b1;
   logic        cmd_valid, cmd_client, drop_a, drop_b, proto_err;
   logic [2:0]  cmd_opcode;
   logic [4:0]  cmd_id;
   logic [31:0] cmd_word;

   int vectors = 0;
   int miscompares = 0;
   bit rand_ready = 0;

   ats21_cmd_ingress #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .ctrlA      (ctrlA),
      .ctrlB      (ctrlB),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_client (cmd_client),
      .cmd_opcode (cmd_opcode),
      .cmd_id     (cmd_id),
      .cmd_word   (cmd_word),
      .drop_a     (drop_a),
      .drop_b     (drop_b),
      .proto_err  (proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference id extraction, computed from the opcode classes arithmetically
   function automatic logic [4:0] ref_id(input logic [31:0] w);
      int unsigned op;
      op = w >> 29;
      if (op == 1 || op == 2) return 5'((w >> 25) % 16);
      if (op >= 5)            return 5'((w >> 24) % 32);
      return 5'd0;
   endfunction

   // Model state: per-client pending instructions and arbitration history
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   bit          last_b = 1;
   bit          held = 0;
   bit          held_cl = 0;
   bit          pend = 0;
   logic [15:0] up_a = '0, up_b = '0;
   bit          exp_da = 0, exp_db = 0, exp_pe = 0;

   // Monitor: compare DUT outputs to the model, then advance the model
   always @(negedge clk) begin
      bit          ev, cl;
      logic [31:0] ew, wa, wb;
      int unsigned opa, opb;
      cl = 0;
      ew = '0;
      chk("drop_a", 64'(drop_a), 64'(exp_da));
      chk("drop_b", 64'(drop_b), 64'(exp_db));
      chk("proto_err", 64'(proto_err), 64'(exp_pe));
      ev = (qa.size() > 0) || (qb.size() > 0);
      chk("cmd_valid", 64'(cmd_valid), 64'(ev));
      if (ev) begin
         if (held)                               cl = held_cl;
         else if (qa.size() > 0 && qb.size() > 0) cl = !last_b;
         else                                    cl = (qa.size() == 0);
         ew = cl ? qb[0] : qa[0];
         chk("cmd_client", 64'(cmd_client), 64'(cl));
         chk("cmd_word", 64'(cmd_word), 64'(ew));
         chk("cmd_opcode", 64'(cmd_opcode), 64'(ew >> 29));
         chk("cmd_id", 64'(cmd_id), 64'(ref_id(ew)));
      end else begin
         chk("idle_outputs", {23'd0, cmd_client, cmd_opcode, cmd_id, cmd_word}, 64'd0);
      end

      if (reset) begin
         qa.delete();
         qb.delete();
         last_b = 1;
         held = 0;
         pend = 0;
         exp_da = 0;
         exp_db = 0;
         exp_pe = 0;
      end else begin
         if (ev && cmd_ready) begin
            if (cl) void'(qb.pop_front());
            else    void'(qa.pop_front());
            last_b = cl;
         end
         held    = ev && !cmd_ready;
         held_cl = cl;
         exp_pe  = pend && req;
         exp_da  = 0;
         exp_db  = 0;
         if (req) begin
            up_a = ctrlA;
            up_b = ctrlB;
            pend = 1;
         end else if (pend) begin
            wa  = {up_a, ctrlA};
            wb  = {up_b, ctrlB};
            opa = wa >> 29;
            opb = wb >> 29;
            if (opa == 4) exp_da = 1;
            else if (opa != 0) begin
               if (qa.size() < DEPTH) qa.push_back(wa);
               else                   exp_da = 1;
            end
            if (opb == 4) exp_db = 1;
            else if (opb != 0) begin
               if (qb.size() < DEPTH) qb.push_back(wb);
               else                   exp_db = 1;
            end
            pend = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) cmd_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(input int n);
      req = 1'b0;
      for (int i = 0; i < n; i++) begin
         ctrlA = 16'($urandom);
         ctrlB = 16'($urandom);
         tick();
      end
   endtask

   task automatic xfer(input logic [15:0] ah, input logic [15:0] al,
                       input logic [15:0] bh, input logic [15:0] bl);
      req = 1'b1;
      ctrlA = ah;
      ctrlB = bh;
      tick();
      req = 1'b0;
      ctrlA = al;
      ctrlB = bl;
      tick();
   endtask

   initial begin
      int r;
      reset = 1'b1;
      #1;
      idle(3);
      reset = 1'b0;
      idle(2);

      // single A instruction
      xfer(16'h2000, 16'h0000, 16'h0000, 16'h0000);
      idle(4);

      // simultaneous A and B
      xfer(16'hA080, 16'h0025, 16'hC602, 16'h0010);
      idle(4);

      // overflow of client A with the core stalled
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         xfer(16'h2000 | 16'(i << 4), 16'(16'h1000 + i), 16'h0000, 16'h0000);
      idle(2);
      cmd_ready = 1'b1;
      idle(8);

      // stall stability with both queues occupied, then alternation
      cmd_ready = 1'b0;
      xfer(16'h4A00, 16'h0001, 16'h6C00, 16'h0002);
      xfer(16'hEF00, 16'h0003, 16'h7100, 16'h0004);
      idle(10);
      cmd_ready = 1'b1;
      idle(8);

      // aborted transfer, then reserved opcode on B
      req = 1'b1; ctrlA = 16'hE111; ctrlB = 16'h0000; tick();
      req = 1'b1; ctrlA = 16'hA222; ctrlB = 16'h0000; tick();
      req = 1'b0; ctrlA = 16'h0033; ctrlB = 16'h0000; tick();
      idle(4);
      xfer(16'h0000, 16'h0000, 16'h8000, 16'h1234);
      idle(4);

      // reset while a pair is half captured and an entry is queued
      cmd_ready = 1'b0;
      xfer(16'h2111, 16'h0001, 16'h0000, 16'h0000);
      req = 1'b1; ctrlA = 16'h4000; tick();
      req = 1'b0; ctrlA = 16'h0005; reset = 1'b1; tick();
      reset = 1'b0;
      idle(2);
      cmd_ready = 1'b1;
      xfer(16'h2000, 16'h0000, 16'h0000, 16'h0000);
      idle(4);

      // randomized traffic
      rand_ready = 1;
      for (int it = 0; it < 400; it++) begin
         r = $urandom_range(0, 19);
         if (r < 4) idle($urandom_range(1, 3));
         else if (r < 16)
            xfer(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         else if (r < 19) begin
            req = 1'b1; ctrlA = 16'($urandom); ctrlB = 16'($urandom); tick();
            xfer(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         end else begin
            req = 1'($urandom); reset = 1'b1; tick();
            reset = 1'b0;
            idle(1);
         end
      end
      rand_ready = 0;
      cmd_ready = 1'b1;
      req = 1'b0;

      // drain with a bounded wait
      for (int i = 0; i < 200 && (qa.size() > 0 || qb.size() > 0); i++) tick();
      chk("drain_done", 64'(qa.size() + qb.size()), 64'd0);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
